// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM state type and the signed-overflow operand constants.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [XLEN-1:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: one shift/add-subtract step per cycle over
// operand magnitudes, sign fix-up on the final step, valid/ready on both sides.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = mdu_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] rd,
    output logic            busy
);

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   addend_q, addend_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rd_q, rd_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_by_zero, div_ovf, last_iter;
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix;

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign rd         = rd_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        f3_d     = f3_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;

        a_signed    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg       = a_signed && rs1[XLEN-1];
        b_neg       = b_signed && rs2[XLEN-1];
        a_mag       = a_neg ? -rs1 : rs1;
        b_mag       = b_neg ? -rs2 : rs2;
        div_by_zero = (rs2 == '0);
        div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1 == INT_MIN) && (rs2 == NEG_ONE);
        last_iter   = (cnt_q == CNT_W'(XLEN - 1));

        mul_sum  = '0;
        prod     = '0;
        prod_fix = '0;
        div_rem  = '0;
        div_diff = '0;
        quot     = '0;
        rem      = '0;
        quot_fix = '0;
        rem_fix  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d    = funct3;
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    cnt_d   = '0;
                    if (!funct3[2]) begin
                        // Multiplier magnitude sits in the low half and is consumed LSB-first.
                        addend_d = a_mag;
                        acc_d    = {{XLEN{1'b0}}, b_mag};
                        state_d  = MUL;
                    end else if (div_by_zero) begin
                        rd_d    = funct3[1] ? rs1 : NEG_ONE;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        rd_d    = funct3[1] ? '0 : INT_MIN;
                        state_d = DONE;
                    end else begin
                        addend_d = b_mag;
                        acc_d    = {{XLEN{1'b0}}, a_mag};
                        state_d  = DIV;
                    end
                end
            end

            MUL: begin
                mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                          (acc_q[0] ? {1'b0, addend_q} : {(XLEN+1){1'b0}});
                prod    = {mul_sum, acc_q[XLEN-1:1]};
                acc_d   = prod;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
                    rd_d     = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end

            DIV: begin
                // Partial remainder lives in the high half, dividend/quotient bits in the low half.
                div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
                div_diff = div_rem - {1'b0, addend_q};
                rem      = div_diff[XLEN] ? div_rem[XLEN-1:0] : div_diff[XLEN-1:0];
                quot     = {acc_q[XLEN-2:0], ~div_diff[XLEN]};
                acc_d    = {rem, quot};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    quot_fix = (a_neg_q ^ b_neg_q) ? -quot : quot;
                    rem_fix  = a_neg_q ? -rem : rem;
                    rd_d     = f3_q[1] ? rem_fix : quot_fix;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end

            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted op leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            f3_q     <= '0;
            addend_q <= '0;
            acc_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            cnt_q    <= '0;
            rd_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            f3_q     <= f3_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: expected results and latencies are queued at accept
// and compared when the response appears; includes back-pressure and mid-op reset.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rd;
    logic        busy;

    mdu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rd         (rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rd;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_acc = 0;
    logic rise_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sbv, ua, ub, p;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (f3)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Response monitor: latency checked on the rising response, rd on consumption.
    always @(negedge clk) begin
        if (rst) begin
            rise_seen = 1'b0;
        end else if (resp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_resp", {31'b0, resp_valid}, 32'h0);
            end else begin
                if (!rise_seen) begin
                    check($sformatf("lat_f3_%0d", sb[0].f3), 32'(cyc - sb[0].acc_cyc),
                          32'(sb[0].lat));
                    rise_seen = 1'b1;
                end
                if (resp_ready) begin
                    check($sformatf("rd_f3_%0d", sb[0].f3), rd, sb[0].rd);
                    void'(sb.pop_front());
                    rise_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, input int exp_lat);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        funct3    = f3;
        rs1       = a;
        rs2       = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'b0, req_ready}, 32'h1);
        end else begin
            e.f3      = f3;
            e.rd      = exp_rd;
            e.lat     = exp_lat;
            e.acc_cyc = cyc;
            sb.push_back(e);
            last_acc  = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic issue_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        issue(f3, a, b, ref_op(f3, a, b), special ? 1 : 33);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int cons_cyc;
        rst        = 1'b1;
        req_valid  = 1'b0;
        funct3     = 3'd0;
        rs1        = '0;
        rs2        = '0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_rd", rd, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);

        // Directed ops; the second issue also measures accept-to-accept throughput.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        a0 = last_acc;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        check("throughput", 32'(last_acc - a0), 32'd34);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 33);
        issue(3'd7, 32'd100, 32'd7, 32'd2, 33);
        issue(3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        issue(3'd7, 32'h1234, 32'd0, 32'h0000_1234, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        wait_idle();

        // Back-pressure: response held for 10 cycles, then a queued request follows.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 32'd14, 33);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        check("bp_resp_seen", {31'b0, resp_valid}, 32'h1);
        repeat (10) begin
            @(negedge clk);
            check("bp_rd", rd, 32'd14);
            check("bp_valid", {31'b0, resp_valid}, 32'h1);
            check("bp_req_ready", {31'b0, req_ready}, 32'h0);
        end
        fork
            issue(3'd7, 32'd100, 32'd7, 32'd2, 33);
        join_none
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        cons_cyc = cyc;
        @(negedge clk);
        check("rel_idle", {31'b0, req_ready}, 32'h1);
        check("rel_valid_drop", {31'b0, resp_valid}, 32'h0);
        wait_idle();
        check("queued_acc_cycle", 32'(last_acc - cons_cyc), 32'd1);

        // Reset during the 15th DIV iteration aborts the op with no response.
        issue(3'd4, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 33);
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("mid_rst_rd", rd, 32'h0);
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_no_resp", {31'b0, resp_valid}, 32'h0);
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        issue(3'd0, 32'd3, 32'd5, 32'd15, 33);

        // Random operands against the reference model, two passes over all funct3.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i < 8) ? $urandom : $urandom_range(1, 1000);
            if (i[0]) b = -b;
            issue_ref(3'(i), a, b);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer.
- Sits beside the single-cycle integer ALU. It takes funct7=0x01 (M-extension) ops off the execute stage and runs them over multiple cycles using one shared shift/add-subtract datapath.
- Uses a valid/ready handshake on both the request and response sides, so the pipeline stalls on `busy`.
- Produces RISC-V-compliant results for all eight M ops, including divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- funct3  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  in  XLEN  operand A (dividend / multiplicand).
- rs2  in  XLEN  operand B (divisor / multiplier).
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer takes the result.
- rd  out  XLEN  result; registered and stable while resp_valid is high.
- busy  out  1  high in every state except IDLE.

Behaviour:

Reset:
- Clock is clk. Reset rst is asynchronous and active-high.
- On reset: state=IDLE, resp_valid=0, rd=0, busy=0, counter=0, all internal registers cleared. req_ready=1 once rst deasserts.
- Reset mid-operation aborts the op silently; no response is ever produced for it.

FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accept on the edge where req_valid&&req_ready. Latch funct3, rs1, rs2, and the sign flags.
  - funct3<4 -> MUL.
  - funct3>=4 with rs2==0, or with signed overflow (funct3 in {4,6}, rs1==0x80000000, rs2==0xFFFFFFFF) -> DONE directly, with rd loaded from the special-case table below.
  - Any other divide -> DIV.
- MUL:
  - Shift-add over |A|,|B| magnitudes. A is treated as signed for MULH/MULHSU; B is treated as signed for MULH only.
  - One multiplier bit per cycle, 2*XLEN accumulator, XLEN cycles.
  - On the last iteration, apply sign fix-up (two's-complement negate when the operand signs differ).
  - Select result: low word for MUL, high word for the others. Load rd, go to DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
  - Signed ops only (DIV/REM) negate per these rules. DIV/REM select quotient/remainder. Load rd, go to DONE.
- DONE:
  - resp_valid=1 and rd held.
  - On resp_valid&&resp_ready, go to IDLE; resp_valid drops the next cycle.
  - No new request is accepted in the same cycle the response is consumed.

Latency:
- Normal op: resp_valid rises exactly XLEN+1 = 33 cycles after the accept edge.
- Special case: 1 cycle after accept.
- Throughput: at most one op per 34 cycles with resp_ready held high.

Special-case results:
- DIV/DIVU by 0 -> 0xFFFFFFFF.
- REM/REMU by 0 -> rs1.
- DIV overflow -> 0x80000000.
- REM overflow -> 0.

Arithmetic rules:
- Negation is XLEN-bit two's complement.
- MULH/MULHSU/MULHU use the full 64-bit product; no truncation before the high-word select.

Inputs outside the IDLE accept cycle are ignored. req_valid held across the DONE->IDLE transition is accepted in IDLE on the following cycle.

Decomposition:
- Package mdu_pkg holds:
  - XLEN default.
  - funct3 localparams F3_MUL..F3_REMU.
  - state enum typedef (IDLE, MUL, DIV, DONE).
  - Overflow constants INT_MIN=0x80000000 and NEG_ONE=0xFFFFFFFF.
- Single module. The shared iterative datapath stays inline; no sub-module.

Test Plan:
- MUL 7*-3: rs1=7, rs2=0xFFFFFFFD, funct3=0 -> rd=0xFFFFFFEB, resp_valid exactly 33 cycles after accept.
- MULH/MULHSU/MULHU with rs1=rs2=0xFFFFFFFF -> rd 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero, rs1=0x1234: DIV -> 0xFFFFFFFF, REMU -> 0x1234; overflow DIV(0x80000000,0xFFFFFFFF) -> 0x80000000, REM -> 0. Each with resp_valid 1 cycle after accept.
- Back-pressure and back-to-back:
  - Hold resp_ready=0 for 10 cycles in DONE -> rd and resp_valid stable, req_ready=0.
  - Release -> IDLE next cycle; a queued request is then accepted.
- Reset at iteration 15 of a DIV -> all outputs return to reset values immediately (async), no resp_valid. A new MUL 3*5 afterwards -> 15.
